// File: rtl/multidigit_counter_7seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multidigit_counter_7seg_pkg
//  Description : Shared constants for the multi-digit counter / 7-segment
//                display block. Segment patterns are active-low, ordered
//                {a,b,c,d,e,f,g} with a as the MSB.
//  Revision    : 1.0  initial release
// ============================================================================
package multidigit_counter_7seg_pkg;

    // Bits per display digit (hex or BCD nibble)
    localparam int c_digit_w = 4;

    localparam logic [6:0] c_seg_0     = 7'b0000001;
    localparam logic [6:0] c_seg_1     = 7'b1001111;
    localparam logic [6:0] c_seg_2     = 7'b0010010;
    localparam logic [6:0] c_seg_3     = 7'b0000110;
    localparam logic [6:0] c_seg_4     = 7'b1001100;
    localparam logic [6:0] c_seg_5     = 7'b0100100;
    localparam logic [6:0] c_seg_6     = 7'b0100000;
    localparam logic [6:0] c_seg_7     = 7'b0001111;
    localparam logic [6:0] c_seg_8     = 7'b0000000;
    localparam logic [6:0] c_seg_9     = 7'b0000100;
    localparam logic [6:0] c_seg_a     = 7'b0001000;
    localparam logic [6:0] c_seg_b     = 7'b1100000;
    localparam logic [6:0] c_seg_c     = 7'b0110001;
    localparam logic [6:0] c_seg_d     = 7'b1000010;
    localparam logic [6:0] c_seg_e     = 7'b0110000;
    localparam logic [6:0] c_seg_f     = 7'b0111000;
    localparam logic [6:0] c_seg_blank = 7'b1111111;

endpackage : multidigit_counter_7seg_pkg
`default_nettype wire

// File: rtl/multidigit_counter_7seg_hex_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg7
//  Description : Combinational nibble to active-low 7-segment decoder.
//  Ports       : hex  [3:0] - nibble to display
//                seg7 [6:0] - active-low segments {a,b,c,d,e,f,g}
//  Revision    : 1.0  initial release
// ============================================================================
module hex_to_seg7
    import multidigit_counter_7seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg7
);

    always_comb begin
        seg7 = c_seg_blank;
        case (hex)
            4'h0: seg7 = c_seg_0;
            4'h1: seg7 = c_seg_1;
            4'h2: seg7 = c_seg_2;
            4'h3: seg7 = c_seg_3;
            4'h4: seg7 = c_seg_4;
            4'h5: seg7 = c_seg_5;
            4'h6: seg7 = c_seg_6;
            4'h7: seg7 = c_seg_7;
            4'h8: seg7 = c_seg_8;
            4'h9: seg7 = c_seg_9;
            4'ha: seg7 = c_seg_a;
            4'hb: seg7 = c_seg_b;
            4'hc: seg7 = c_seg_c;
            4'hd: seg7 = c_seg_d;
            4'he: seg7 = c_seg_e;
            4'hf: seg7 = c_seg_f;
            default: seg7 = c_seg_blank;
        endcase
    end

endmodule : hex_to_seg7
`default_nettype wire

// File: rtl/multidigit_counter_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : multidigit_counter_7seg
//  Description : Prescaled up/down multi-digit counter with loadable value,
//                terminal-count pulse on wrap, and a time-multiplexed
//                active-low 7-segment display driver.
//  Parameters  : DIGITS - number of digits (1..8)
//                DIV    - clock cycles per count tick (>=1)
//                SCAN   - clock cycles each digit stays lit (>=1)
//  Ports       : clk, rst (sync, active-high), enable, upDown (1=up),
//                load, loadValue[4*DIGITS-1:0] -> count[4*DIGITS-1:0],
//                tc (wrap pulse), seg7[6:0] (active-low), an[DIGITS-1:0]
//                (active-low digit select)
//  Config      : BCD_MODE_EN - when defined, digits count decimal 0..9 and
//                loaded nibbles above 9 are forced to 0; otherwise hex.
//  Revision    : 1.0  initial release
// ============================================================================
module multidigit_counter_7seg
    import multidigit_counter_7seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 1,
    parameter int SCAN   = 4
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          upDown,
    input  logic                          load,
    input  logic [c_digit_w*DIGITS-1:0]   loadValue,
    output logic [c_digit_w*DIGITS-1:0]   count,
    output logic                          tc,
    output logic [6:0]                    seg7,
    output logic [DIGITS-1:0]             an
);

    localparam int c_cw = c_digit_w * DIGITS;
    localparam int c_pw = (DIV    > 1) ? $clog2(DIV)    : 1;
    localparam int c_sw = (SCAN   > 1) ? $clog2(SCAN)   : 1;
    localparam int c_iw = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef BCD_MODE_EN
    localparam logic [c_digit_w-1:0] c_digit_max = 4'd9;
`else
    localparam logic [c_digit_w-1:0] c_digit_max = 4'd15;
`endif

    logic [c_pw-1:0]      r_presc;
    logic [c_sw-1:0]      r_scan;
    logic [c_iw-1:0]      r_index;
    logic [c_cw-1:0]      r_count;
    logic                 r_tc;
    logic [6:0]           r_seg7;
    logic [DIGITS-1:0]    r_an;

    logic                 w_tick;
    logic                 w_scan_end;
    logic [c_cw-1:0]      w_next;
    logic                 w_wrap;
    logic [c_cw-1:0]      w_load;
    logic [c_digit_w-1:0] w_nib;
    logic [6:0]           w_seg;

    assign w_tick     = (r_presc == c_pw'(DIV - 1));
    assign w_scan_end = (r_scan  == c_sw'(SCAN - 1));

    // Ripple the +/-1 across digits; each digit rolls between 0 and
    // c_digit_max, and a carry/borrow out of the top digit is the wrap.
    always_comb begin
        w_next = r_count;
        w_wrap = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_wrap) begin
                if (upDown) begin
                    if (r_count[d*c_digit_w +: c_digit_w] == c_digit_max) begin
                        w_next[d*c_digit_w +: c_digit_w] = '0;
                    end else begin
                        w_next[d*c_digit_w +: c_digit_w] =
                            r_count[d*c_digit_w +: c_digit_w] + 4'd1;
                        w_wrap = 1'b0;
                    end
                end else begin
                    if (r_count[d*c_digit_w +: c_digit_w] == '0) begin
                        w_next[d*c_digit_w +: c_digit_w] = c_digit_max;
                    end else begin
                        w_next[d*c_digit_w +: c_digit_w] =
                            r_count[d*c_digit_w +: c_digit_w] - 4'd1;
                        w_wrap = 1'b0;
                    end
                end
            end
        end
    end

    // Load value, with non-decimal nibbles cleared in BCD mode
    always_comb begin
        w_load = loadValue;
`ifdef BCD_MODE_EN
        for (int d = 0; d < DIGITS; d++) begin
            if (loadValue[d*c_digit_w +: c_digit_w] > 4'd9) begin
                w_load[d*c_digit_w +: c_digit_w] = '0;
            end
        end
`endif
    end

    // Prescaler free-runs independently of enable and load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_load;
            r_tc    <= 1'b0;
        end else if (enable && w_tick) begin
            r_count <= w_next;
            r_tc    <= w_wrap;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan  <= '0;
            r_index <= '0;
        end else if (w_scan_end) begin
            r_scan  <= '0;
            r_index <= (r_index == c_iw'(DIGITS - 1)) ? '0 : r_index + 1'b1;
        end else begin
            r_scan  <= r_scan + 1'b1;
        end
    end

    assign w_nib = r_count[r_index*c_digit_w +: c_digit_w];

    hex_to_seg7 u_dec (
        .hex  (w_nib),
        .seg7 (w_seg)
    );

    // an and seg7 share one register stage so they always change together
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an   <= ~DIGITS'(1);
            r_seg7 <= c_seg_0;
        end else begin
            r_an   <= ~(DIGITS'(1) << r_index);
            r_seg7 <= w_seg;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign seg7  = r_seg7;
    assign an    = r_an;

endmodule : multidigit_counter_7seg
`default_nettype wire

// File: tb/tb_multidigit_counter_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multidigit_counter_7seg
//  Description : Directed self-checking bench, DIGITS=2 DIV=2 SCAN=2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multidigit_counter_7seg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       upDown = 1'b0;
    logic       load = 1'b0;
    logic [7:0] loadValue = 8'h00;
    logic [7:0] count;
    logic       tc;
    logic [6:0] seg7;
    logic [1:0] an;

    int n_checks = 0;
    int n_errors = 0;

    multidigit_counter_7seg #(.DIGITS(2), .DIV(2), .SCAN(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .upDown    (upDown),
        .load      (load),
        .loadValue (loadValue),
        .count     (count),
        .tc        (tc),
        .seg7      (seg7),
        .an        (an)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_change(input string tag);
        logic [7:0] prev;
        logic       seen;
        prev = count;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (count !== prev) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic do_load(input logic [7:0] v);
        load      = 1'b1;
        loadValue = v;
        step();
        load      = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [7:0] start, input logic dir,
                            input logic [7:0] exp_cnt, input logic exp_tc);
        enable = 1'b0;
        upDown = dir;
        do_load(start);
        enable = 1'b1;
        wait_change(tag);
        check({tag, "_count"}, 32'(count), 32'(exp_cnt));
        check({tag, "_tc"}, 32'(tc), 32'(exp_tc));
        enable = 1'b0;
    endtask

    logic [1:0] first_an;
    logic [1:0] exp_an;
    logic       seen_an;

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) step();
        check("rst_count", 32'(count), 32'h00);
        check("rst_tc",    32'(tc),    32'd0);
        check("rst_an",    32'(an),    32'b10);
        check("rst_seg7",  32'(seg7),  32'b0000001);

        // Down from 0 wraps to FF with tc
        rst    = 1'b0;
        enable = 1'b1;
        upDown = 1'b0;
        wait_change("dn_wrap");
        check("dn_wrap_count", 32'(count), 32'hFF);
        check("dn_wrap_tc",    32'(tc),    32'd1);
        step();
        enable = 1'b0;
        check("dn_wrap_tc_pulse", 32'(tc), 32'd0);
        seen_an = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (an == 2'b10) begin
                seen_an = 1'b1;
                break;
            end
        end
        check("ff_an0_seen", 32'(seen_an), 32'd1);
        check("ff_seg7_d0",  32'(seg7), 32'b0111000);

        // Up from FE: FF, then 00 with tc
        do_load(8'hFE);
        check("load_fe", 32'(count), 32'hFE);
        check("load_fe_tc", 32'(tc), 32'd0);
        upDown = 1'b1;
        enable = 1'b1;
        wait_change("up1");
        check("up1_count", 32'(count), 32'hFF);
        check("up1_tc",    32'(tc),    32'd0);
        wait_change("up2");
        check("up2_count", 32'(count), 32'h00);
        check("up2_tc",    32'(tc),    32'd1);
        step();
        check("up2_tc_pulse", 32'(tc), 32'd0);

        // Load coincident with tick and enable: next edge is a tick
        load      = 1'b1;
        loadValue = 8'h3C;
        step();
        load      = 1'b0;
        check("load_tick_count", 32'(count), 32'h3C);
        check("load_tick_tc",    32'(tc),    32'd0);
        enable = 1'b0;

        // Hold at 5A while display scans
        do_load(8'h5A);
        step();
        first_an = an;
        seen_an  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (an != first_an) begin
                seen_an = 1'b1;
                break;
            end
        end
        check("scan_toggle_seen", 32'(seen_an), 32'd1);
        first_an = an;
        for (int i = 0; i < 20; i++) begin
            exp_an = (((i / 2) % 2) == 0) ? first_an : ~first_an;
            check("scan_an", 32'(an), 32'(exp_an));
            check("scan_seg7", 32'(seg7), (exp_an == 2'b10) ? 32'b0001000 : 32'b0100100);
            upDown = ~upDown;
            step();
        end
        check("hold_count", 32'(count), 32'h5A);
        check("hold_tc",    32'(tc),    32'd0);

        // Reset mid-count overrides load and step
        do_load(8'h37);
        enable    = 1'b1;
        upDown    = 1'b1;
        rst       = 1'b1;
        load      = 1'b1;
        loadValue = 8'h99;
        step();
        load = 1'b0;
        rst  = 1'b0;
        check("midrst_count", 32'(count), 32'h00);
        check("midrst_an",    32'(an),    32'b10);
        check("midrst_seg7",  32'(seg7),  32'b0000001);
        check("midrst_tc",    32'(tc),    32'd0);
        wait_change("resume");
        check("resume_count", 32'(count), 32'h01);
        enable = 1'b0;

`ifdef BCD_MODE_EN
        run_case("bcd_09_up", 8'h09, 1'b1, 8'h10, 1'b0);
        run_case("bcd_99_up", 8'h99, 1'b1, 8'h00, 1'b1);
        run_case("bcd_00_dn", 8'h00, 1'b0, 8'h99, 1'b1);
        run_case("bcd_10_dn", 8'h10, 1'b0, 8'h09, 1'b0);
        do_load(8'hA5);
        check("bcd_load_clip", 32'(count), 32'h05);
`else
        run_case("hex_09_up", 8'h09, 1'b1, 8'h0A, 1'b0);
        run_case("hex_10_dn", 8'h10, 1'b0, 8'h0F, 1'b0);
        run_case("hex_4f_up", 8'h4F, 1'b1, 8'h50, 1'b0);
        do_load(8'hA5);
        check("hex_load_a5", 32'(count), 32'hA5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_multidigit_counter_7seg
`default_nettype wire
